ps2_scan_decoder: RTL and testbench

- Sits directly downstream of the PS/2 byte receiver (PS2Interface).
- Consumes received bytes, sequences the scan-code-set-2 prefix protocol (E0 extended, F0 break), and emits one decoded key event per complete sequence.
- Events are buffered in a small FIFO and drained by the system-bus/CPU side through a valid/ready handshake.
- Also flags protocol errors, stale prefixes (timeout) and FIFO overflow.

---
 rtl/ps2_pkg.sv | 37 +++
 rtl/ps2_event_fifo.sv | 70 +++++++
 rtl/ps2_scan_decoder.sv | 187 ++++++++++++++++++
 tb/tb_ps2_scan_decoder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, FSM state and event types for the PS/2 scan-code-set-2 decoder.
// Optional shift tracking in the decoder is enabled with PS2_SHIFT_TRACK_EN.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BRK    = 8'hF0;
   localparam logic [7:0] PS2_BAT    = 8'hAA;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_RESEND = 8'hFE;
   localparam logic [7:0] PS2_ECHO   = 8'hEE;
   localparam logic [7:0] PS2_LSHIFT = 8'h12;
   localparam logic [7:0] PS2_RSHIFT = 8'h59;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      S_E0   = 2'd1,
      S_F0   = 2'd2,
      S_E0F0 = 2'd3
   } ps2_state_e;

   typedef struct packed {
      logic       ext;
      logic       rel;
      logic [7:0] code;
   } ps2_event_t;

   // Keyboard self-test/acknowledge traffic that carries no key information.
   function automatic logic is_status_byte(input logic [7:0] b);
      return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_RESEND) ||
             (b == PS2_ECHO) || (b == 8'h00) || (b == 8'hFF);
   endfunction

   function automatic logic is_prefix_byte(input logic [7:0] b);
      return (b == PS2_EXT) || (b == PS2_BRK);
   endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous FIFO for decoded key events; head is read straight from the storage flops.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module ps2_event_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 10,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push;
   logic             do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) begin
         mem_d[wr_q] = push_data;
         wr_d        = wr_q + AW'(1);
      end
      if (do_pop) begin
         rd_d = rd_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign head  = mem_q[rd_q];
   assign count = cnt_q;

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 prefix sequencer (E0/F0) feeding an event FIFO, with timeout, error and overflow flags.
// Define PS2_SHIFT_TRACK_EN to add the shift_held output.
module ps2_scan_decoder
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [7:0]                  byte_in,
   input  logic                        byte_valid,
   output logic [7:0]                  key_code,
   output logic                        key_ext,
   output logic                        key_rel,
   output logic                        key_valid,
   input  logic                        key_ready,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow,
   input  logic                        clr_overflow,
   output logic                        proto_err
`ifdef PS2_SHIFT_TRACK_EN
   ,
   output logic                        shift_held
`endif
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);

   ps2_state_e state_q, state_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          tmo_hit;
   logic          perr_q, perr_d;
   logic          ovf_q, ovf_d;
   logic          push_en;
   ps2_event_t    push_evt;
   logic [9:0]    head_w;
   ps2_event_t    head_evt;
   logic          fifo_full;
   logic          fifo_empty;
   logic          ovf_set;

   // A byte arriving in the expiry cycle wins over the timeout.
   assign tmo_hit = (state_q != IDLE) && !byte_valid &&
                    (tmo_q == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (byte_valid) begin
         case (state_q)
            IDLE: begin
               if (byte_in == PS2_EXT)      state_d = S_E0;
               else if (byte_in == PS2_BRK) state_d = S_F0;
            end
            S_E0: begin
               if (byte_in == PS2_BRK)      state_d = S_E0F0;
               else if (byte_in != PS2_EXT) state_d = IDLE;
            end
            S_F0:    state_d = IDLE;
            S_E0F0:  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end else if (tmo_hit) begin
         state_d = IDLE;
      end
   end

   always_comb begin
      push_en       = 1'b0;
      push_evt.ext  = 1'b0;
      push_evt.rel  = 1'b0;
      push_evt.code = byte_in;
      perr_d        = 1'b0;
      if (byte_valid) begin
         case (state_q)
            IDLE: begin
               push_en = !is_prefix_byte(byte_in) && !is_status_byte(byte_in);
            end
            S_E0: begin
               push_en      = !is_prefix_byte(byte_in);
               push_evt.ext = 1'b1;
            end
            S_F0: begin
               push_en      = !is_prefix_byte(byte_in);
               perr_d       = is_prefix_byte(byte_in);
               push_evt.rel = 1'b1;
            end
            S_E0F0: begin
               push_en      = !is_prefix_byte(byte_in);
               perr_d       = is_prefix_byte(byte_in);
               push_evt.ext = 1'b1;
               push_evt.rel = 1'b1;
            end
            default: ;
         endcase
      end else if (tmo_hit) begin
         perr_d = 1'b1;
      end
   end

   always_comb begin
      tmo_d = tmo_q + TW'(1);
      if (byte_valid || state_q == IDLE || tmo_hit) begin
         tmo_d = '0;
      end
   end

   // A pop in the same cycle frees the slot, so only a pop-less full push drops.
   assign ovf_set = push_en && fifo_full && !(key_ready && !fifo_empty);

   always_comb begin
      ovf_d = ovf_q;
      if (ovf_set)           ovf_d = 1'b1;
      else if (clr_overflow) ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tmo_q  <= '0;
         perr_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         tmo_q  <= tmo_d;
         perr_q <= perr_d;
         ovf_q  <= ovf_d;
      end
   end

   ps2_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(ps2_event_t))
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_en),
      .push_data (push_evt),
      .pop       (key_ready),
      .head      (head_w),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign head_evt  = head_w;
   assign key_code  = head_evt.code;
   assign key_ext   = head_evt.ext;
   assign key_rel   = head_evt.rel;
   assign key_valid = !fifo_empty;
   assign overflow  = ovf_q;
   assign proto_err = perr_q;

`ifdef PS2_SHIFT_TRACK_EN
   logic lsh_q, lsh_d;
   logic rsh_q, rsh_d;

   // Tracks decoded events, so a dropped FIFO push still updates shift state.
   always_comb begin
      lsh_d = lsh_q;
      rsh_d = rsh_q;
      if (push_en && !push_evt.ext) begin
         if (push_evt.code == PS2_LSHIFT) lsh_d = !push_evt.rel;
         if (push_evt.code == PS2_RSHIFT) rsh_d = !push_evt.rel;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lsh_q <= 1'b0;
         rsh_q <= 1'b0;
      end else begin
         lsh_q <= lsh_d;
         rsh_q <= rsh_d;
      end
   end

   assign shift_held = lsh_q | rsh_q;
`endif

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Bench for ps2_scan_decoder: directed steps then random bytes against a queue-based model.
// Shift tracking is checked when PS2_SHIFT_TRACK_EN is defined.
module tb_ps2_scan_decoder;

   localparam int DEPTH = 8;
   localparam int TMO   = 20;

   logic       clk          = 1'b0;
   logic       rst_n        = 1'b0;
   logic [7:0] byte_in      = 8'h00;
   logic       byte_valid   = 1'b0;
   logic       key_ready    = 1'b0;
   logic       clr_overflow = 1'b0;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_rel;
   logic       key_valid;
   logic [3:0] fifo_count;
   logic       overflow;
   logic       proto_err;
`ifdef PS2_SHIFT_TRACK_EN
   logic       shift_held;
   logic       m_lsh;
   logic       m_rsh;
`endif

   int         total = 0;
   int         bad   = 0;

   // Model: pending-prefix flags, expected event queue and flag expectations.
   logic [9:0] exp_q[$];
   logic       m_ext;
   logic       m_brk;
   logic       m_ovf;
   logic       m_ovf_set;
   logic       m_perr;
   int         idle_run;
   logic [7:0] status_list [6];

   always #5 clk = ~clk;

   ps2_scan_decoder #(
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .byte_in      (byte_in),
      .byte_valid   (byte_valid),
      .key_code     (key_code),
      .key_ext      (key_ext),
      .key_rel      (key_rel),
      .key_valid    (key_valid),
      .key_ready    (key_ready),
      .fifo_count   (fifo_count),
      .overflow     (overflow),
      .clr_overflow (clr_overflow),
      .proto_err    (proto_err)
`ifdef PS2_SHIFT_TRACK_EN
      ,
      .shift_held   (shift_held)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic is_status(input logic [7:0] b);
      return b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
   endfunction

   task automatic m_push(input logic e, input logic r, input logic [7:0] c);
`ifdef PS2_SHIFT_TRACK_EN
      if (!e && c == 8'h12) m_lsh = !r;
      if (!e && c == 8'h59) m_rsh = !r;
`endif
      if (exp_q.size() < DEPTH) exp_q.push_back({e, r, c});
      else m_ovf_set = 1'b1;
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic pfx;
      pfx = (b == 8'hE0) || (b == 8'hF0);
      if (!m_ext && !m_brk) begin
         if (b == 8'hE0)       m_ext = 1'b1;
         else if (b == 8'hF0)  m_brk = 1'b1;
         else if (!is_status(b)) m_push(1'b0, 1'b0, b);
      end else if (pfx && m_brk) begin
         m_perr = 1'b1;
         m_ext  = 1'b0;
         m_brk  = 1'b0;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else if (b != 8'hE0) begin
         m_push(m_ext, m_brk, b);
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   task automatic check_state();
      chk("key_valid", 32'(key_valid), 32'(exp_q.size() > 0));
      chk("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("proto_err", 32'(proto_err), 32'(m_perr));
      if (exp_q.size() > 0) begin
         chk("head_event", 32'({key_ext, key_rel, key_code}), 32'(exp_q[0]));
      end
`ifdef PS2_SHIFT_TRACK_EN
      chk("shift_held", 32'(shift_held), 32'(m_lsh | m_rsh));
`endif
   endtask

   // One clock cycle: drive inputs, advance the model, then check after the edge.
   task automatic tick(input logic v, input logic [7:0] b, input logic rdy, input logic clr);
      byte_valid   = v;
      byte_in      = b;
      key_ready    = rdy;
      clr_overflow = clr;
      m_perr       = 1'b0;
      m_ovf_set    = 1'b0;
      if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
      if (v) begin
         idle_run = 0;
         model_byte(b);
      end else begin
         idle_run++;
         if ((m_ext || m_brk) && idle_run == TMO) begin
            m_perr = 1'b1;
            m_ext  = 1'b0;
            m_brk  = 1'b0;
         end
      end
      if (m_ovf_set) m_ovf = 1'b1;
      else if (clr)  m_ovf = 1'b0;
      @(negedge clk);
      byte_valid   = 1'b0;
      key_ready    = 1'b0;
      clr_overflow = 1'b0;
      check_state();
   endtask

   task automatic send(input logic [7:0] b);
      tick(1'b1, b, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) tick(1'b0, 8'h00, rdy, 1'b0);
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      byte_valid   = 1'b0;
      key_ready    = 1'b0;
      clr_overflow = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      m_ext    = 1'b0;
      m_brk    = 1'b0;
      m_ovf    = 1'b0;
      m_perr   = 1'b0;
      idle_run = 0;
`ifdef PS2_SHIFT_TRACK_EN
      m_lsh = 1'b0;
      m_rsh = 1'b0;
      chk("rst_shift_held", 32'(shift_held), 32'd0);
`endif
      chk("rst_key_valid", 32'(key_valid), 32'd0);
      chk("rst_key_code", 32'(key_code), 32'd0);
      chk("rst_key_ext", 32'(key_ext), 32'd0);
      chk("rst_key_rel", 32'(key_rel), 32'd0);
      chk("rst_fifo_count", 32'(fifo_count), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_proto_err", 32'(proto_err), 32'd0);
   endtask

   initial begin
      logic [7:0] rb;
      int         sel;
      status_list = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

      do_reset();

      // Plain make, one-cycle latency, head held while not accepted.
      send(8'h1C);
      chk("make_1c_event", 32'({key_ext, key_rel, key_code}), 32'h01C);
      idle(5, 1'b0);
      chk("make_1c_stable", 32'(key_code), 32'h1C);
      idle(1, 1'b1);

      // Extended break, plain break, status bytes (back to back).
      send(8'hE0); send(8'hF0); send(8'h75);
      chk("ext_brk_event", 32'({key_ext, key_rel, key_code}), 32'h375);
      send(8'hF0); send(8'h1C);
      send(8'hAA); send(8'hFA);
      chk("count_after_status", 32'(fifo_count), 32'd2);
      idle(3, 1'b1);

      // Illegal prefix pair, then recovery.
      send(8'hF0); send(8'hE0);
      chk("f0_e0_err", 32'(proto_err), 32'd1);
      send(8'h1C);
      chk("recover_1c", 32'({key_ext, key_rel, key_code}), 32'h01C);
      idle(1, 1'b1);

      // Stale E0 times out; then a byte decodes as a plain make.
      send(8'hE0);
      idle(TMO + 2, 1'b0);
      send(8'h75);
      chk("after_timeout", 32'({key_ext, key_rel, key_code}), 32'h075);
      idle(1, 1'b1);

      // Byte landing exactly on the expiry cycle is decoded normally.
      send(8'hE0);
      idle(TMO - 1, 1'b0);
      send(8'h75);
      chk("expiry_edge", 32'({key_ext, key_rel, key_code}), 32'h275);
      idle(1, 1'b1);

      // Overflow: DEPTH+2 codes with no consumer.
      for (int i = 1; i <= DEPTH + 2; i++) send(8'(i));
      chk("ovf_count", 32'(fifo_count), 32'(DEPTH));
      chk("ovf_flag", 32'(overflow), 32'd1);
      idle(DEPTH, 1'b1);
      tick(1'b0, 8'h00, 1'b0, 1'b1);
      chk("ovf_cleared", 32'(overflow), 32'd0);

      // Full FIFO: push coinciding with a pop is accepted.
      for (int i = 0; i < DEPTH; i++) send(8'(8'h20 + i));
      tick(1'b1, 8'h33, 1'b1, 1'b0);
      chk("full_pushpop_count", 32'(fifo_count), 32'(DEPTH));
      chk("full_pushpop_ovf", 32'(overflow), 32'd0);
      idle(DEPTH, 1'b1);

      // Reset in the middle of an extended sequence.
      send(8'hE0);
      do_reset();
      send(8'h1C);
      chk("post_reset_make", 32'({key_ext, key_rel, key_code}), 32'h01C);
      idle(1, 1'b1);

`ifdef PS2_SHIFT_TRACK_EN
      send(8'h12);
      chk("lshift_make", 32'(shift_held), 32'd1);
      send(8'h59); send(8'hF0); send(8'h12);
      chk("rshift_still", 32'(shift_held), 32'd1);
      send(8'hF0); send(8'h59);
      chk("shift_released", 32'(shift_held), 32'd0);
      idle(6, 1'b1);
`endif

      // Random byte streams with random consumer, gaps and clears.
      for (int n = 0; n < 600; n++) begin
         sel = int'($urandom_range(0, 9));
         case (sel)
            0:       rb = 8'hE0;
            1:       rb = 8'hF0;
            2:       rb = status_list[$urandom_range(0, 5)];
            3:       rb = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
            default: rb = 8'($urandom_range(1, 127));
         endcase
         tick($urandom_range(0, 2) != 0, rb, $urandom_range(0, 3) == 0,
              $urandom_range(0, 15) == 0);
         if ($urandom_range(0, 40) == 0) idle(TMO + 1, $urandom_range(0, 1) == 0);
      end
      idle(DEPTH + 2, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
